// File: rtl/inst_mem_dumper_if.sv
// Bundles the instruction-memory read port and the outgoing byte stream
// of inst_mem_dumper. master = dumper side, slave = memory / TX sink side.
interface inst_mem_dumper_if;
    logic        inst_mem_rd_en;
    logic [31:0] inst_mem_rd_addr;
    logic [31:0] inst_mem_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output inst_mem_rd_en,
        output inst_mem_rd_addr,
        input  inst_mem_rd_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  inst_mem_rd_en,
        input  inst_mem_rd_addr,
        output inst_mem_rd_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/inst_mem_dumper.sv
// inst_mem_dumper: reads a range of instruction-memory words and streams
// each word out as 4 bytes, MSB first, over a valid/ready byte interface.
// Optional feature macro: DUMP_CHECKSUM_EN appends one XOR checksum byte
// covering every byte of the dump before completion.
module inst_mem_dumper #(
    parameter int MEM_DEPTH_WORDS = 256,
    parameter int CNT_W           = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          start_addr,
    input  logic [CNT_W-1:0]     word_count,
    output logic                 busy,
    output logic                 done,
    inst_mem_dumper_if.master    bus
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, NEXT, CKSUM, FINISH} state_t;
    // After the last word the checksum byte goes out before completion.
    localparam state_t LAST_ST = CKSUM;
`else
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, NEXT, FINISH} state_t;
    localparam state_t LAST_ST = FINISH;
`endif

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEM_DEPTH_WORDS);
    localparam logic [31:0]      MEM_BYTES = 32'(4 * MEM_DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      rd_addr_q, rd_addr_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]       cksum_q, cksum_d;
`endif

    logic             rd_en;
    logic [31:0]      rd_addr;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic [CNT_W-1:0] cnt_clamped;
    logic [7:0]       word_bytes [4];

    // Byte lanes of the captured word, lane 0 being the most significant.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign word_bytes[gi] = word_q[31-8*gi -: 8];
    end

    assign cnt_clamped = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;

    // State register and datapath registers; reset abandons any dump in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            rd_addr_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            rd_addr_q  <= rd_addr_d;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        rd_addr_d  = rd_addr_q;
`ifdef DUMP_CHECKSUM_EN
        cksum_d    = cksum_q;
`endif
        rd_en      = 1'b0;
        rd_addr    = rd_addr_q;   // read address holds between reads
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = {start_addr[31:2], 2'b00};
                    cnt_d  = cnt_clamped;
`ifdef DUMP_CHECKSUM_EN
                    cksum_d = 8'h00;
`endif
                    state_d = (cnt_clamped == '0) ? LAST_ST : READ;
                end
            end
            READ: begin
                rd_en     = 1'b1;
                rd_addr   = addr_q;
                rd_addr_d = addr_q;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                // Memory data is valid the cycle after the strobe.
                word_d     = bus.inst_mem_rd_data;
                byte_idx_d = 2'd0;
                state_d    = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = word_bytes[byte_idx_q];
                if (bus.tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    cksum_d = cksum_q ^ word_bytes[byte_idx_q];
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = NEXT;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            NEXT: begin
                addr_d  = (addr_q + 32'd4) % MEM_BYTES;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? LAST_ST : READ;
            end
`ifdef DUMP_CHECKSUM_EN
            CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = cksum_q;
                if (bus.tx_ready) begin
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy                 = (state_q != IDLE);
    assign bus.inst_mem_rd_en   = rd_en;
    assign bus.inst_mem_rd_addr = rd_addr;
    assign bus.tx_data          = tx_data;
    assign bus.tx_valid         = tx_valid;

endmodule

// File: tb/tb_inst_mem_dumper.sv
// Directed bench for inst_mem_dumper: basic dump, backpressure, empty dump,
// address wrap, count clamp, reset mid-dump and start while busy.
module tb_inst_mem_dumper;
    localparam int DEPTH = 256;
    localparam int CNT_W = 9;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      start_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;

    inst_mem_dumper_if bus_if();

    inst_mem_dumper #(.MEM_DEPTH_WORDS(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: registered read, data one cycle after strobe.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus_if.inst_mem_rd_en)
            bus_if.inst_mem_rd_data <= mem[bus_if.inst_mem_rd_addr[9:2]];
    end

    // Sink ready: always high (mode 0) or high one cycle in three (mode 1).
    int ready_mode;
    initial begin
        int cyc;
        cyc = 0;
        bus_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus_if.tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // Monitor: records accepted bytes, read addresses, done pulses, stability.
    logic [7:0]  got_bytes [$];
    logic [31:0] got_addr  [$];
    int rd_cnt, done_cnt, done_ncyc, ncyc, stall_err;
    logic busy_at_done;
    initial begin
        logic       stalled;
        logic [7:0] stall_data;
        rd_cnt = 0; done_cnt = 0; done_ncyc = 0; ncyc = 0; stall_err = 0;
        busy_at_done = 1'b0;
        stalled = 1'b0; stall_data = 8'h00;
        forever begin
            @(negedge clk);
            ncyc++;
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (bus_if.inst_mem_rd_en) begin
                    rd_cnt++;
                    got_addr.push_back(bus_if.inst_mem_rd_addr);
                end
                if (stalled && !(bus_if.tx_valid && bus_if.tx_data == stall_data))
                    stall_err++;
                stalled    = bus_if.tx_valid && !bus_if.tx_ready;
                stall_data = bus_if.tx_data;
                if (bus_if.tx_valid && bus_if.tx_ready)
                    got_bytes.push_back(bus_if.tx_data);
                if (done) begin
                    done_cnt++;
                    done_ncyc    = ncyc;
                    busy_at_done = busy;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int b_base, a_base, rd_base, done_base, stall_base, start_ncyc;

    task automatic launch(input logic [31:0] sa, input logic [CNT_W-1:0] wc);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = sa;
        word_count = wc;
        b_base     = got_bytes.size();
        a_base     = got_addr.size();
        rd_base    = rd_cnt;
        done_base  = done_cnt;
        stall_base = stall_err;
        @(posedge clk); #1;
        start_ncyc = ncyc;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, " done_seen"}, 32'(done_cnt - done_base), 32'd1);
        @(posedge clk); #1;
        chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, " done_once"}, 32'(done_cnt - done_base), 32'd1);
        $display("dump %s: bytes=%0d reads=%0d done_at=%0d", tag,
                 got_bytes.size() - b_base, rd_cnt - rd_base, done_ncyc - start_ncyc);
    endtask

    task automatic expect_words(input string tag, input int n,
                                input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0]  exp_b [$];
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int j = 0; j < 4; j++) begin
                exp_b.push_back(w[31-8*j -: 8]);
                x = x ^ w[31-8*j -: 8];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        exp_b.push_back(x);
`endif
        chk({tag, " nbytes"}, 32'(got_bytes.size() - b_base), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++) begin
            if (b_base + i < got_bytes.size())
                chk($sformatf("%s byte%0d", tag, i), {24'd0, got_bytes[b_base + i]}, {24'd0, exp_b[i]});
        end
    endtask

    task automatic expect_addrs(input string tag, input int n,
                                input logic [31:0] a0, input logic [31:0] a1);
        chk({tag, " nreads"}, 32'(got_addr.size() - a_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (a_base + i < got_addr.size())
                chk($sformatf("%s addr%0d", tag, i), got_addr[a_base + i], (i == 0) ? a0 : a1);
        end
    endtask

    initial begin
        int n;
        int rd_snap, done_snap;
        reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
        ready_mode = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[0]   = 32'h3C0B00F0;
        mem[1]   = 32'h01600008;
        mem[255] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy",     {31'd0, busy}, 32'd0);
        chk("rst done",     {31'd0, done}, 32'd0);
        chk("rst tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
        chk("rst tx_data",  {24'd0, bus_if.tx_data}, 32'd0);
        chk("rst rd_en",    {31'd0, bus_if.inst_mem_rd_en}, 32'd0);
        chk("rst rd_addr",  bus_if.inst_mem_rd_addr, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Basic two-word dump with the sink always ready.
        launch(32'h0, 9'd2);
        wait_done("basic", 100);
        expect_words("basic", 2, 32'h3C0B00F0, 32'h01600008);
        expect_addrs("basic", 2, 32'h0, 32'h4);
`ifdef DUMP_CHECKSUM_EN
        chk("basic done_at", 32'(done_ncyc - start_ncyc), 32'd16);
`else
        chk("basic done_at", 32'(done_ncyc - start_ncyc), 32'd15);
`endif
        chk("basic busy_at_done", {31'd0, busy_at_done}, 32'd1);

        // Same dump with the sink ready one cycle in three.
        ready_mode = 1;
        launch(32'h0, 9'd2);
        wait_done("bp", 300);
        expect_words("bp", 2, 32'h3C0B00F0, 32'h01600008);
        expect_addrs("bp", 2, 32'h0, 32'h4);
        chk("bp stable", 32'(stall_err - stall_base), 32'd0);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        // Empty dump: no reads, immediate completion.
        launch(32'h10, 9'd0);
        wait_done("zero", 20);
        chk("zero reads", 32'(rd_cnt - rd_base), 32'd0);
        expect_words("zero", 0, 32'h0, 32'h0);
`ifdef DUMP_CHECKSUM_EN
        chk("zero done_at", 32'(done_ncyc - start_ncyc), 32'd2);
`else
        chk("zero done_at", 32'(done_ncyc - start_ncyc), 32'd1);
`endif

        // Unaligned start at the top of memory wraps to address 0.
        launch(32'h3FE, 9'd2);
        wait_done("wrap", 100);
        expect_addrs("wrap", 2, 32'h3FC, 32'h0);
        expect_words("wrap", 2, 32'hDEADBEEF, 32'h3C0B00F0);

        // Oversized count clamps to the memory depth.
        launch(32'h0, 9'd300);
        wait_done("clamp", 4000);
        chk("clamp reads", 32'(rd_cnt - rd_base), 32'd256);
`ifdef DUMP_CHECKSUM_EN
        chk("clamp nbytes", 32'(got_bytes.size() - b_base), 32'd1025);
`else
        chk("clamp nbytes", 32'(got_bytes.size() - b_base), 32'd1024);
`endif
        chk("clamp last_addr", got_addr[got_addr.size() - 1], 32'h3FC);

        // Reset while the second byte of the first word is presented.
        launch(32'h0, 9'd2);
        n = 0;
        while (got_bytes.size() < b_base + 1 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rstmid first_byte", 32'(got_bytes.size() - b_base), 32'd1);
        @(posedge clk); #1;
        chk("rstmid byte1_valid", {31'd0, bus_if.tx_valid}, 32'd1);
        chk("rstmid byte1_data", {24'd0, bus_if.tx_data}, 32'h0B);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
        chk("rstmid busy",     {31'd0, busy}, 32'd0);
        chk("rstmid done",     {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_snap = rd_cnt; done_snap = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid no_reads", 32'(rd_cnt - rd_snap), 32'd0);
        chk("rstmid no_done",  32'(done_cnt - done_snap), 32'd0);
        launch(32'h4, 9'd1);
        wait_done("restart", 100);
        expect_addrs("restart", 1, 32'h4, 32'h0);
        expect_words("restart", 1, 32'h01600008, 32'h0);

        // A start pulse during SEND must be ignored.
        launch(32'h0, 9'd2);
        n = 0;
        while (!bus_if.tx_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("busystart in_send", {31'd0, bus_if.tx_valid}, 32'd1);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 32'h40; word_count = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busystart", 100);
        expect_addrs("busystart", 2, 32'h0, 32'h4);
        expect_words("busystart", 2, 32'h3C0B00F0, 32'h01600008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
